// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and opcode bounds.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    NOP = 3'h0,
    ADD = 3'h1,
    SUB = 3'h2,
    AND = 3'h3,
    OR  = 3'h4,
    SLT = 3'h5
  } op_type_t;

  localparam logic [OP_W-1:0] OP_MAX = 3'h5;

endpackage : alu_pkg

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Scan ptr, ptr+1, ... mod N; the winner moves the pointer just past itself.
  always_comb begin
    grant = '0;
    found = 1'b0;
    gidx  = ptr_q;
    idx   = '0;
    ptr_d = ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PTR_W'((32'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        gidx       = idx;
      end
    end
    if (advance && found) begin
      ptr_d = (32'(gidx) + 32'd1 == N) ? '0 : PTR_W'(32'(gidx) + 32'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arbiter

// File: rtl/alu_arbiter.sv
// Shares one fixed-latency alu among NUM_REQ requesters; tags each issued op and
// routes the result back to its owner ALU_LAT cycles later.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALU_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*OP_W-1:0]  req_op,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic [OP_W-1:0]          alu_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  input  logic [WIDTH-1:0]         alu_out
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned LAST = ALU_LAT - 1;

  logic [NUM_REQ-1:0] busy_q, busy_d;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               any_grant;
  logic [ID_W-1:0]    gidx;
  logic [OP_W-1:0]    sel_op;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic               illegal;

  logic [ALU_LAT-1:0] vld_q, vld_d;
  logic [ALU_LAT-1:0] err_q, err_d;
  logic [ID_W-1:0]    id_q [ALU_LAT];
  logic [ID_W-1:0]    id_d [ALU_LAT];

  // A requester with an op in flight sits out until its response returns.
  assign eligible = req_valid & ~busy_q;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (eligible),
    .advance (1'b1),
    .grant   (grant)
  );

  // Operand mux and index encode for the granted requester.
  always_comb begin
    any_grant = |grant;
    gidx      = '0;
    sel_op    = NOP;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx   = ID_W'(i);
        sel_op = req_op[i*OP_W +: OP_W];
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
      end
    end
    illegal   = any_grant && (sel_op > OP_MAX);
    req_ready = grant;
    alu_op    = (any_grant && !illegal) ? sel_op : NOP;
    alu_a     = sel_a;
    alu_b     = sel_b;
  end

  // Tag pipe tracks the alu pipeline; its last stage selects the result owner.
  always_comb begin
    vld_d    = '0;
    err_d    = '0;
    id_d     = id_q;
    vld_d[0] = any_grant;
    err_d[0] = illegal;
    id_d[0]  = gidx;
    for (int unsigned s = 1; s < ALU_LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      err_d[s] = err_q[s-1];
      id_d[s]  = id_q[s-1];
    end
  end

  // Response demux; data and err are forced to zero when nothing returns.
  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = vld_q[LAST] && (id_q[LAST] == ID_W'(i));
    end
    rsp_data = vld_q[LAST] ? alu_out : '0;
    rsp_err  = vld_q[LAST] && err_q[LAST];
    busy_d   = (busy_q | grant) & ~rsp_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      vld_q  <= '0;
      err_q  <= '0;
      for (int unsigned s = 0; s < ALU_LAT; s++) begin
        id_q[s] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
      id_q   <= id_d;
    end
  end

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// Directed bench: alu_arbiter driving a two-stage reference alu, NUM_REQ=4, WIDTH=32.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*OP_W-1:0] req_op = '0;
  logic [N*W-1:0]    req_a = '0;
  logic [N*W-1:0]    req_b = '0;
  logic [N-1:0]      rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic [OP_W-1:0]   alu_op;
  logic [W-1:0]      alu_a, alu_b;
  logic [W-1:0]      alu_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .WIDTH(W), .ALU_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out)
  );

  // Reference alu: registered inputs, registered output.
  logic [OP_W-1:0] op_r;
  logic [W-1:0]    a_r, b_r;

  function automatic logic [W-1:0] alu_f(input logic [OP_W-1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      3'h1:    return a + b;
      3'h2:    return a - b;
      3'h3:    return a & b;
      3'h4:    return a | b;
      3'h5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      alu_out <= '0;
    end else begin
      op_r    <= alu_op;
      a_r     <= alu_a;
      b_r     <= alu_b;
      alu_out <= alu_f(op_r, a_r, b_r);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]         = v;
    req_op[i*OP_W +: OP_W] = op;
    req_a[i*W +: W]      = a;
    req_b[i*W +: W]      = b;
  endtask

  // Enter the next cycle: inputs change after the falling edge, checks follow 1ns later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst       = 1'b1;
    req_valid = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(); settle();
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_err", 64'(rsp_err), 64'h0);
    chk("rst_alu_op", 64'(alu_op), 64'(NOP));
    chk("rst_alu_a", 64'(alu_a), 64'h0);
    chk("rst_alu_b", 64'(alu_b), 64'h0);
    do_reset();

    // 1: single ADD 5+7
    cyc(); set_req(0, 1'b1, 3'h1, 32'd5, 32'd7); settle();
    chk("t1_ready", 64'(req_ready), 64'h1);
    chk("t1_alu_op", 64'(alu_op), 64'h1);
    chk("t1_alu_a", 64'(alu_a), 64'd5);
    chk("t1_alu_b", 64'(alu_b), 64'd7);
    cyc(); req_valid = '0; settle();
    chk("t1_rsp_early", 64'(rsp_valid), 64'h0);
    chk("t1_idle_alu_op", 64'(alu_op), 64'(NOP));
    cyc(); settle();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t1_rsp_data", 64'(rsp_data), 64'd12);
    chk("t1_rsp_err", 64'(rsp_err), 64'h0);
    cyc(); settle();
    chk("t1_rsp_done", 64'(rsp_valid), 64'h0);
    chk("t1_data_zero", 64'(rsp_data), 64'h0);

    // 2: all four SUB 10-3 from reset
    do_reset();
    cyc();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'h2, 32'd10, 32'd3);
    settle();
    chk("t2_ready_c0", 64'(req_ready), 64'h1);
    cyc(); req_valid[0] = 1'b0; settle();
    chk("t2_ready_c1", 64'(req_ready), 64'h2);
    cyc(); req_valid[1] = 1'b0; settle();
    chk("t2_ready_c2", 64'(req_ready), 64'h4);
    chk("t2_rsp0", 64'(rsp_valid), 64'h1);
    chk("t2_rsp0_data", 64'(rsp_data), 64'd7);
    cyc(); req_valid[2] = 1'b0; settle();
    chk("t2_ready_c3", 64'(req_ready), 64'h8);
    chk("t2_rsp1", 64'(rsp_valid), 64'h2);
    chk("t2_rsp1_data", 64'(rsp_data), 64'd7);
    cyc(); req_valid[3] = 1'b0; settle();
    chk("t2_rsp2", 64'(rsp_valid), 64'h4);
    chk("t2_rsp2_data", 64'(rsp_data), 64'd7);
    cyc(); settle();
    chk("t2_rsp3", 64'(rsp_valid), 64'h8);
    chk("t2_rsp3_data", 64'(rsp_data), 64'd7);

    // 3: req0 held back-to-back (1+2), req1 held (4+4) fills the busy gaps
    cyc();
    set_req(0, 1'b1, 3'h1, 32'd1, 32'd2);
    set_req(1, 1'b1, 3'h1, 32'd4, 32'd4);
    settle();
    chk("t3_u0_ready", 64'(req_ready), 64'h1);
    cyc(); settle();
    chk("t3_u1_ready", 64'(req_ready), 64'h2);
    cyc(); settle();
    chk("t3_u2_ready", 64'(req_ready), 64'h0);
    chk("t3_u2_rsp", 64'(rsp_valid), 64'h1);
    chk("t3_u2_data", 64'(rsp_data), 64'd3);
    cyc(); settle();
    chk("t3_u3_ready", 64'(req_ready), 64'h1);
    chk("t3_u3_rsp", 64'(rsp_valid), 64'h2);
    chk("t3_u3_data", 64'(rsp_data), 64'd8);
    cyc(); settle();
    chk("t3_u4_ready", 64'(req_ready), 64'h2);
    cyc(); settle();
    chk("t3_u5_ready", 64'(req_ready), 64'h0);
    chk("t3_u5_rsp", 64'(rsp_valid), 64'h1);
    cyc(); settle();
    chk("t3_u6_ready", 64'(req_ready), 64'h1);
    chk("t3_u6_rsp", 64'(rsp_valid), 64'h2);
    cyc(); req_valid = '0; settle();
    chk("t3_u7_rsp", 64'(rsp_valid), 64'h0);
    cyc(); settle();
    chk("t3_u8_rsp", 64'(rsp_valid), 64'h1);
    chk("t3_u8_data", 64'(rsp_data), 64'd3);

    // 4: illegal opcode on req2 (pointer now at 1)
    cyc(); set_req(2, 1'b1, 3'h7, 32'd1, 32'd1); settle();
    chk("t4_ready", 64'(req_ready), 64'h4);
    chk("t4_alu_op", 64'(alu_op), 64'(NOP));
    cyc(); req_valid = '0; settle();
    chk("t4_rsp_early", 64'(rsp_valid), 64'h0);
    cyc(); settle();
    chk("t4_rsp", 64'(rsp_valid), 64'h4);
    chk("t4_data", 64'(rsp_data), 64'h0);
    chk("t4_err", 64'(rsp_err), 64'h1);
    cyc(); settle();
    chk("t4_err_clear", 64'(rsp_err), 64'h0);

    // 5: reset while req1 is in flight (pointer now at 3)
    cyc(); set_req(1, 1'b1, 3'h1, 32'd2, 32'd2); settle();
    chk("t5_ready", 64'(req_ready), 64'h2);
    cyc(); rst = 1'b1; req_valid = '0; settle();
    chk("t5_rst_rsp", 64'(rsp_valid), 64'h0);
    cyc(); settle();
    chk("t5_no_rsp", 64'(rsp_valid), 64'h0);
    chk("t5_no_err", 64'(rsp_err), 64'h0);
    cyc(); rst = 1'b0;
    set_req(1, 1'b1, 3'h1, 32'd5, 32'd6);
    set_req(3, 1'b1, 3'h1, 32'd0, 32'd0);
    settle();
    chk("t5_post_rst_grant", 64'(req_ready), 64'h2);

    // 6: req3 granted (pointer wraps to 0), then req0 beats req3
    cyc(); req_valid[1] = 1'b0; settle();
    chk("t6_grant3", 64'(req_ready), 64'h8);
    cyc(); req_valid[3] = 1'b0; settle();
    chk("t6_rsp1", 64'(rsp_valid), 64'h2);
    chk("t6_rsp1_data", 64'(rsp_data), 64'd11);
    cyc(); settle();
    chk("t6_rsp3", 64'(rsp_valid), 64'h8);
    chk("t6_rsp3_data", 64'(rsp_data), 64'd0);
    cyc();
    set_req(0, 1'b1, 3'h5, 32'd3, 32'd9);
    set_req(3, 1'b1, 3'h5, 32'd3, 32'd9);
    settle();
    chk("t6_req0_wins", 64'(req_ready), 64'h1);
    chk("t6_alu_op", 64'(alu_op), 64'h5);
    cyc(); req_valid[0] = 1'b0; settle();
    chk("t6_then_req3", 64'(req_ready), 64'h8);
    cyc(); req_valid[3] = 1'b0; settle();
    chk("t6_rsp0", 64'(rsp_valid), 64'h1);
    chk("t6_slt_data", 64'(rsp_data), 64'd1);
    cyc(); settle();
    chk("t6_rsp3b", 64'(rsp_valid), 64'h8);
    chk("t6_slt3_data", 64'(rsp_data), 64'd1);
    cyc(); settle();
    chk("t6_idle", 64'(rsp_valid), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_arbiter
